// File: rtl/alu_md_if.sv
// Request/response bundle for alu_md: request side (in_*, operands, opcode)
// and result side (out_*, S, HI, LO, div_zero).
interface alu_md_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [5:0]       ALUFun;
  logic             Sign;
  logic [1:0]       MD;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             div_zero;

  modport master (
    output in_valid, A, B, ALUFun, Sign, MD, out_ready,
    input  in_ready, out_valid, S, HI, LO, div_zero
  );

  modport slave (
    input  in_valid, A, B, ALUFun, Sign, MD, out_ready,
    output in_ready, out_valid, S, HI, LO, div_zero
  );
endinterface

// File: rtl/alu_md.sv
// ALU with iterative multiply/divide. Single-cycle ALU ops land in DONE on
// the accept edge; MULT/DIV iterate one bit per BUSY cycle on operand
// magnitudes and apply the result sign on the last BUSY cycle.
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      reset,
  alu_md_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0]     LAST_CNT = SHW'(WIDTH-1);
  localparam logic [SHW-1:0]     CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  // Two's-complement negation helpers used for magnitude/sign handling.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + ONE_2W;
  endfunction

  state_t             state_r;
  logic [WIDTH-1:0]   s_r, hi_r, lo_r;
  logic               dz_r;
  logic [SHW-1:0]     cnt_r;
  logic               is_div_r, b_zero_r, neg_res_r, neg_rem_r;
  logic [WIDTH-1:0]   a_r;
  logic [2*WIDTH-1:0] mcand_r, prod_r;
  logic [WIDTH-1:0]   mplier_r, rem_r, quo_r, dvs_r;

  logic               in_ready_s, accept_s, is_md_s;
  logic               neg_a_s, neg_b_s, lt_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, alu_s;
  logic [SHW-1:0]     sh_s;
  logic [2*WIDTH-1:0] prod_step_s, mul_fin_s;
  logic [WIDTH:0]     shifted_s, diff_s;
  logic [WIDTH-1:0]   rem_step_s, quo_step_s, div_lo_s, div_hi_s;

  assign in_ready_s = (state_r == IDLE) | ((state_r == DONE) & bus.out_ready);
  assign accept_s   = bus.in_valid & in_ready_s;
  assign is_md_s    = (bus.MD == 2'b01) | (bus.MD == 2'b10);

  assign neg_a_s = bus.Sign & bus.A[WIDTH-1];
  assign neg_b_s = bus.Sign & bus.B[WIDTH-1];
  assign mag_a_s = neg_a_s ? neg_w(bus.A) : bus.A;
  assign mag_b_s = neg_b_s ? neg_w(bus.B) : bus.B;

  assign sh_s = bus.A[SHW-1:0];
  assign lt_s = bus.Sign ? ($signed(bus.A) < $signed(bus.B)) : (bus.A < bus.B);

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == DONE);
  assign bus.S         = s_r;
  assign bus.HI        = hi_r;
  assign bus.LO        = lo_r;
  assign bus.div_zero  = dz_r;

  // Single-cycle ALU/compare result from the request currently offered.
  always_comb begin
    alu_s = bus.A;
    case (bus.ALUFun)
      6'b000000: alu_s = bus.A + bus.B;
      6'b000001: alu_s = bus.A - bus.B;
      6'b011000: alu_s = bus.A & bus.B;
      6'b011110: alu_s = bus.A | bus.B;
      6'b010110: alu_s = bus.A ^ bus.B;
      6'b010001: alu_s = ~(bus.A | bus.B);
      6'b011010: alu_s = bus.A;
      6'b100000: alu_s = bus.B << sh_s;
      6'b100001: alu_s = bus.B >> sh_s;
      6'b100011: alu_s = $signed(bus.B) >>> sh_s;
      6'b110011: alu_s = {{(WIDTH-1){1'b0}}, (bus.A == bus.B)};
      6'b110001: alu_s = {{(WIDTH-1){1'b0}}, (bus.A != bus.B)};
      6'b110101: alu_s = {{(WIDTH-1){1'b0}}, lt_s};
      6'b111011: alu_s = {{(WIDTH-1){1'b0}}, bus.A[WIDTH-1]};
      6'b111101: alu_s = {{(WIDTH-1){1'b0}}, (bus.A[WIDTH-1] | (bus.A == {WIDTH{1'b0}}))};
      6'b111111: alu_s = {{(WIDTH-1){1'b0}}, (~bus.A[WIDTH-1] & (bus.A != {WIDTH{1'b0}}))};
      default:   alu_s = bus.A;
    endcase
  end

  // One shift-add and one restoring-divide step, plus the sign-corrected finals.
  always_comb begin
    prod_step_s = mplier_r[0] ? (prod_r + mcand_r) : prod_r;
    mul_fin_s   = neg_res_r ? neg_2w(prod_step_s) : prod_step_s;
    shifted_s   = {rem_r, quo_r[WIDTH-1]};
    diff_s      = shifted_s - {1'b0, dvs_r};
    if (!diff_s[WIDTH]) begin
      rem_step_s = diff_s[WIDTH-1:0];
      quo_step_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_step_s = shifted_s[WIDTH-1:0];
      quo_step_s = {quo_r[WIDTH-2:0], 1'b0};
    end
    if (b_zero_r) begin
      div_lo_s = {WIDTH{1'b1}};
      div_hi_s = a_r;
    end else begin
      div_lo_s = neg_res_r ? neg_w(quo_step_s) : quo_step_s;
      div_hi_s = neg_rem_r ? neg_w(rem_step_s) : rem_step_s;
    end
  end

  // Control FSM with the result and iteration registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= IDLE;
      s_r       <= {WIDTH{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      dz_r      <= 1'b0;
      cnt_r     <= {SHW{1'b0}};
      is_div_r  <= 1'b0;
      b_zero_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      a_r       <= {WIDTH{1'b0}};
      mcand_r   <= {(2*WIDTH){1'b0}};
      prod_r    <= {(2*WIDTH){1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      quo_r     <= {WIDTH{1'b0}};
      dvs_r     <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            if (is_md_s) begin
              cnt_r     <= {SHW{1'b0}};
              is_div_r  <= (bus.MD == 2'b10);
              b_zero_r  <= (bus.B == {WIDTH{1'b0}});
              neg_res_r <= neg_a_s ^ neg_b_s;
              neg_rem_r <= neg_a_s;
              a_r       <= bus.A;
              mcand_r   <= {{WIDTH{1'b0}}, mag_a_s};
              prod_r    <= {(2*WIDTH){1'b0}};
              mplier_r  <= mag_b_s;
              rem_r     <= {WIDTH{1'b0}};
              quo_r     <= mag_a_s;
              dvs_r     <= mag_b_s;
              state_r   <= BUSY;
            end else begin
              s_r     <= alu_s;
              state_r <= DONE;
            end
          end else if ((state_r == DONE) && bus.out_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        BUSY: begin
          prod_r   <= prod_step_s;
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          rem_r    <= rem_step_s;
          quo_r    <= quo_step_s;
          cnt_r    <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            state_r <= DONE;
            if (is_div_r) begin
              hi_r <= div_hi_s;
              lo_r <= div_lo_s;
              s_r  <= div_lo_s;
              dz_r <= b_zero_r;
            end else begin
              hi_r <= mul_fin_s[2*WIDTH-1:WIDTH];
              lo_r <= mul_fin_s[WIDTH-1:0];
              s_r  <= mul_fin_s[WIDTH-1:0];
              dz_r <= 1'b0;
            end
          end else begin
            state_r <= BUSY;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
